instr_queue: RTL and testbench

Parametrised, clocked successor to the instruction register. Holds up to DEPTH instruction words in FIFO order between memory fetch and the decode stage. Captures a word on IRWrite and presents the oldest word on IRRead. Adds occupancy flags, a flush for taken branches, and sticky overflow/underflow error flags.

---
 rtl/instr_queue.sv | 82 ++++++++
 tb/tb_instr_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// FIFO instruction queue between fetch and decode: registered dequeue output,
// occupancy flags, branch flush and sticky overflow/underflow error flags.
module instr_queue #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] int_in,
  input  logic             IRWrite,
  input  logic             IRRead,
  input  logic             flush,
  output logic [WIDTH-1:0] int_out,
  output logic             out_valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             err_overflow,
  output logic             err_underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A read frees a slot in the same cycle, so a write on full is accepted with it.
  assign rd_ok = IRRead & ~empty & ~flush;
  assign wr_ok = IRWrite & ~flush & (~full | IRRead);

  // Storage is never cleared; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= int_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      int_out       <= '0;
      out_valid     <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_ok;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        int_out <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (IRWrite && full && !IRRead) begin
        err_overflow <= 1'b1;
      end
      if (IRRead && empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: default 16x4 instance for the functional
// cases, plus a 32x8 instance exercising pointer wrap with streaming traffic.
module tb_instr_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: WIDTH 16, DEPTH 4
  logic        a_rst, a_wr, a_rd, a_flush;
  logic [15:0] a_in, a_out;
  logic        a_vld, a_full, a_empty, a_ovf, a_unf;
  logic [2:0]  a_count;

  instr_queue dut_a (
    .clk(clk), .rst(a_rst), .int_in(a_in), .IRWrite(a_wr), .IRRead(a_rd),
    .flush(a_flush), .int_out(a_out), .out_valid(a_vld), .full(a_full),
    .empty(a_empty), .count(a_count), .err_overflow(a_ovf), .err_underflow(a_unf)
  );

  // Instance B: WIDTH 32, DEPTH 8
  logic        b_rst, b_wr, b_rd, b_flush;
  logic [31:0] b_in, b_out;
  logic        b_vld, b_full, b_empty, b_ovf, b_unf;
  logic [3:0]  b_count;

  instr_queue #(.WIDTH(32), .DEPTH(8)) dut_b (
    .clk(clk), .rst(b_rst), .int_in(b_in), .IRWrite(b_wr), .IRRead(b_rd),
    .flush(b_flush), .int_out(b_out), .out_valid(b_vld), .full(b_full),
    .empty(b_empty), .count(b_count), .err_overflow(b_ovf), .err_underflow(b_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic wr, input logic rd, input logic fl, input logic [15:0] d);
    a_wr = wr; a_rd = rd; a_flush = fl; a_in = d;
    tick();
    a_wr = 1'b0; a_rd = 1'b0; a_flush = 1'b0;
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_w;
  logic [31:0] nxt;
  int          exp_cnt;
  logic        did_rd;

  initial begin
    a_rst = 1'b1; a_wr = 1'b0; a_rd = 1'b0; a_flush = 1'b0; a_in = '0;
    b_rst = 1'b1; b_wr = 1'b0; b_rd = 1'b0; b_flush = 1'b0; b_in = '0;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;
    tick();

    // Reset state
    check("rst_count", 32'(a_count), 32'd0);
    check("rst_empty", 32'(a_empty), 32'd1);
    check("rst_full", 32'(a_full), 32'd0);
    check("rst_int_out", 32'(a_out), 32'h0000);
    check("rst_out_valid", 32'(a_vld), 32'd0);
    check("rst_ovf", 32'(a_ovf), 32'd0);
    check("rst_unf", 32'(a_unf), 32'd0);

    // Fill to full
    a_drive(1, 0, 0, 16'hA001);
    check("wr1_count", 32'(a_count), 32'd1);
    check("wr1_empty", 32'(a_empty), 32'd0);
    a_drive(1, 0, 0, 16'hA002);
    a_drive(1, 0, 0, 16'hA003);
    a_drive(1, 0, 0, 16'hA004);
    check("fill_full", 32'(a_full), 32'd1);
    check("fill_count", 32'(a_count), 32'd4);

    // Write on full is dropped
    a_drive(1, 0, 0, 16'hBEEF);
    check("ovf_count", 32'(a_count), 32'd4);
    check("ovf_flag", 32'(a_ovf), 32'd1);
    check("ovf_no_unf", 32'(a_unf), 32'd0);

    // Back-to-back drain
    a_rd = 1'b1;
    tick(); check("drain1", 32'(a_out), 32'hA001); check("drain1_vld", 32'(a_vld), 32'd1);
    tick(); check("drain2", 32'(a_out), 32'hA002); check("drain2_vld", 32'(a_vld), 32'd1);
    tick(); check("drain3", 32'(a_out), 32'hA003); check("drain3_vld", 32'(a_vld), 32'd1);
    tick(); check("drain4", 32'(a_out), 32'hA004); check("drain4_vld", 32'(a_vld), 32'd1);
    a_rd = 1'b0;
    check("drain_empty", 32'(a_empty), 32'd1);
    tick();
    check("drain_vld_drop", 32'(a_vld), 32'd0);
    check("drain_hold", 32'(a_out), 32'hA004);
    check("drain_ovf_sticky", 32'(a_ovf), 32'd1);

    // Read+write on full
    a_drive(1, 0, 0, 16'hA011);
    a_drive(1, 0, 0, 16'hA012);
    a_drive(1, 0, 0, 16'hA013);
    a_drive(1, 0, 0, 16'hA014);
    a_drive(1, 1, 0, 16'hC0DE);
    check("rw_full_out", 32'(a_out), 32'hA011);
    check("rw_full_vld", 32'(a_vld), 32'd1);
    check("rw_full_count", 32'(a_count), 32'd4);
    a_drive(0, 1, 0, 16'h0); check("rw_drain1", 32'(a_out), 32'hA012);
    a_drive(0, 1, 0, 16'h0); check("rw_drain2", 32'(a_out), 32'hA013);
    a_drive(0, 1, 0, 16'h0); check("rw_drain3", 32'(a_out), 32'hA014);
    a_drive(0, 1, 0, 16'h0); check("rw_drain4", 32'(a_out), 32'hC0DE);
    check("rw_empty", 32'(a_empty), 32'd1);

    // Underflow and read+write on empty
    a_drive(0, 1, 0, 16'h0);
    check("unf_flag", 32'(a_unf), 32'd1);
    check("unf_vld", 32'(a_vld), 32'd0);
    check("unf_hold", 32'(a_out), 32'hC0DE);
    a_drive(1, 1, 0, 16'h1234);
    check("rw_empty_count", 32'(a_count), 32'd1);
    check("rw_empty_vld", 32'(a_vld), 32'd0);
    a_drive(0, 1, 0, 16'h0);
    check("rw_empty_out", 32'(a_out), 32'h1234);
    check("rw_empty_vld2", 32'(a_vld), 32'd1);
    check("rw_empty_cnt0", 32'(a_count), 32'd0);

    // Flush: reset errors first so flush cycles can be seen not to raise them
    a_rst = 1'b1; tick(); a_rst = 1'b0;
    check("rst2_out", 32'(a_out), 32'h0000);
    check("rst2_unf", 32'(a_unf), 32'd0);
    a_drive(1, 0, 0, 16'h0777);
    a_drive(0, 1, 0, 16'h0);
    check("pre_flush_out", 32'(a_out), 32'h0777);
    a_drive(1, 0, 0, 16'h0111);
    a_drive(1, 0, 0, 16'h0222);
    a_drive(1, 0, 0, 16'h0333);
    a_drive(1, 0, 0, 16'h0444);
    check("pre_flush_full", 32'(a_full), 32'd1);
    a_drive(1, 1, 1, 16'h0999);
    check("flush_count", 32'(a_count), 32'd0);
    check("flush_empty", 32'(a_empty), 32'd1);
    check("flush_vld", 32'(a_vld), 32'd0);
    check("flush_hold", 32'(a_out), 32'h0777);
    check("flush_ovf", 32'(a_ovf), 32'd0);
    check("flush_unf", 32'(a_unf), 32'd0);
    a_drive(0, 1, 1, 16'h0);
    check("flush_empty_unf", 32'(a_unf), 32'd0);
    a_drive(1, 0, 0, 16'h5555);
    a_drive(0, 1, 0, 16'h0);
    check("post_flush_out", 32'(a_out), 32'h5555);
    check("post_flush_empty", 32'(a_empty), 32'd1);

    // Wide/deep instance: streaming across pointer wrap
    exp_cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      b_wr = (cyc < 16);
      b_rd = (cyc >= 4);
      b_in = 32'hD000_0000 + 32'(cyc);
      did_rd = b_rd && (exp_cnt > 0);
      if (did_rd) exp_w = q.pop_front();
      if (b_wr) q.push_back(b_in);
      exp_cnt = q.size();
      tick();
      if (did_rd) check("wrap_out", b_out, exp_w);
      check("wrap_vld", 32'(b_vld), 32'(did_rd));
      check("wrap_count", 32'(b_count), 32'(exp_cnt));
    end
    b_wr = 1'b0; b_rd = 1'b0;

    // Fill the deep instance to full, then drain in order
    for (int k = 0; k < 8; k++) begin
      b_wr = 1'b1; b_in = 32'hE000_0000 + 32'(k);
      tick();
    end
    b_wr = 1'b0;
    check("b_full", 32'(b_full), 32'd1);
    check("b_count8", 32'(b_count), 32'd8);
    b_rd = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      nxt = 32'hE000_0000 + 32'(k);
      check("b_drain", b_out, nxt);
    end
    b_rd = 1'b0;
    check("b_empty", 32'(b_empty), 32'd1);
    check("b_ovf", 32'(b_ovf), 32'd0);
    check("b_unf", 32'(b_unf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
